// File: rtl/aba_pkg.sv
// Shared definitions for the pipelined subtractor aba_sub_pipe.
// Holds the segment width, the stage-count derivation and the payload that
// travels between register stages.
package aba_pkg;

  localparam int LCA_WIDTH = 4;
  localparam int ABA_WIDTH = 17;

  // One register stage per 4-bit segment; the extra MSB rides in the last stage.
  function automatic int nseg_of(input int width);
    return (width - 1) / LCA_WIDTH;
  endfunction

  localparam int NSEG = nseg_of(ABA_WIDTH);

  // diff holds the segments resolved so far (low bits first); a_rem/bn_rem
  // carry the operands (b already inverted) for the segments still to come.
  typedef struct packed {
    logic                 valid;
    logic [ABA_WIDTH-1:0] diff;
    logic                 carry;
    logic [ABA_WIDTH-1:0] a_rem;
    logic [ABA_WIDTH-1:0] bn_rem;
  } stage_t;

endpackage

// File: rtl/LCA4bit.sv
// 4-bit carry-lookahead adder slice used for every segment of aba_sub_pipe.
module LCA4bit
  import aba_pkg::*;
(
  input  logic [LCA_WIDTH-1:0] a,
  input  logic [LCA_WIDTH-1:0] b,
  input  logic                 cin,
  output logic [LCA_WIDTH-1:0] sum,
  output logic                 cout
);

  logic [LCA_WIDTH-1:0] g;
  logic [LCA_WIDTH-1:0] p;
  logic [LCA_WIDTH:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Flattened lookahead carries, all derived directly from cin.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (&p & c[0]);

  assign sum  = p ^ c[LCA_WIDTH-1:0];
  assign cout = c[LCA_WIDTH];

endmodule

// File: rtl/aba_sub_pipe.sv
// Pipelined unsigned subtractor: out_diff = a - b mod 2^WIDTH computed as
// a + ~b + 1, one 4-bit segment per register stage, MSB full-adder in the
// last stage. out_borrow is the inverted final carry.
// Build option: define ABA_SUB_APPROX_EN to skip segment 0 (low nibble
// replicated from a[3], a[3] used as carry into segment 1). Latency and
// handshake are unchanged.
module aba_sub_pipe
  import aba_pkg::stage_t, aba_pkg::nseg_of, aba_pkg::ABA_WIDTH;
#(
  parameter int WIDTH     = 17,
  parameter int LCA_WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_borrow
);

  localparam int NSEG = nseg_of(WIDTH);
  localparam int LAST = NSEG - 1;

  // The stage payload is sized by the package, so WIDTH must match it.
  if (WIDTH != ABA_WIDTH || LCA_WIDTH != 4 || WIDTH != 4 * NSEG + 1 || NSEG < 2) begin : g_bad_cfg
    $error("aba_sub_pipe: unsupported WIDTH/LCA_WIDTH combination");
  end

  logic                 en;
  stage_t               pipe [NSEG-1];
  stage_t               nxt  [NSEG-1];
  logic [LCA_WIDTH-1:0] seg_sum  [NSEG];
  logic                 seg_cout [NSEG];
  logic                 msb_a;
  logic                 msb_b;
  logic                 msb_sum;
  logic                 msb_cout;
  logic                 unused_bits;

  // Whole pipeline moves as one; a stalled output freezes every stage.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

`ifdef ABA_SUB_APPROX_EN
  localparam int SEG_LO = 1;
  assign seg_sum[0]  = {LCA_WIDTH{a[LCA_WIDTH-1]}};
  assign seg_cout[0] = a[LCA_WIDTH-1];
`else
  localparam int SEG_LO = 0;
`endif

  // Segment 0 works on the live inputs; segment k on stage k-1's payload.
  for (genvar k = SEG_LO; k < NSEG; k++) begin : g_seg
    logic [LCA_WIDTH-1:0] sa;
    logic [LCA_WIDTH-1:0] sb;
    logic                 ci;
    if (k == 0) begin : g_first
      assign sa = a[LCA_WIDTH-1:0];
      assign sb = ~b[LCA_WIDTH-1:0];
      assign ci = 1'b1;
    end else begin : g_next
      assign sa = pipe[k-1].a_rem[k*LCA_WIDTH +: LCA_WIDTH];
      assign sb = pipe[k-1].bn_rem[k*LCA_WIDTH +: LCA_WIDTH];
      assign ci = pipe[k-1].carry;
    end
    LCA4bit u_lca (
      .a    (sa),
      .b    (sb),
      .cin  (ci),
      .sum  (seg_sum[k]),
      .cout (seg_cout[k])
    );
  end

  // Next payload for each intermediate stage: splice in the newly resolved segment.
  always_comb begin
    nxt[0]                          = '0;
    nxt[0].valid                    = in_valid;
    nxt[0].diff[LCA_WIDTH-1:0]      = seg_sum[0];
    nxt[0].carry                    = seg_cout[0];
    nxt[0].a_rem                    = a;
    nxt[0].bn_rem                   = ~b;
    for (int k = 1; k < NSEG - 1; k++) begin
      nxt[k]                                   = pipe[k-1];
      nxt[k].diff[k*LCA_WIDTH +: LCA_WIDTH]    = seg_sum[k];
      nxt[k].carry                             = seg_cout[k];
    end
  end

  assign msb_a    = pipe[NSEG-2].a_rem[WIDTH-1];
  assign msb_b    = pipe[NSEG-2].bn_rem[WIDTH-1];
  assign msb_sum  = msb_a ^ msb_b ^ seg_cout[LAST];
  assign msb_cout = (msb_a & msb_b) | (seg_cout[LAST] & (msb_a ^ msb_b));

  // Already-consumed operand bits and not-yet-filled diff bits of the final payload.
  assign unused_bits = ^{pipe[NSEG-2].a_rem[LAST*LCA_WIDTH-1:0],
                         pipe[NSEG-2].bn_rem[LAST*LCA_WIDTH-1:0],
                         pipe[NSEG-2].diff[WIDTH-1:LAST*LCA_WIDTH]};

  // Stage registers; data only loads alongside a valid item so bubbles do not toggle it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSEG - 1; k++) pipe[k] <= '0;
      out_valid  <= 1'b0;
      out_diff   <= '0;
      out_borrow <= 1'b0;
    end else if (en) begin
      for (int k = 0; k < NSEG - 1; k++) begin
        if (nxt[k].valid) pipe[k] <= nxt[k];
        else              pipe[k].valid <= 1'b0;
      end
      out_valid <= pipe[NSEG-2].valid;
      if (pipe[NSEG-2].valid) begin
        out_diff   <= {msb_sum, seg_sum[LAST], pipe[NSEG-2].diff[LAST*LCA_WIDTH-1:0]};
        out_borrow <= ~msb_cout;
      end
    end
  end

endmodule

// File: tb/tb_aba_sub_pipe.sv
// Self-checking bench for aba_sub_pipe (WIDTH=17). Follows ABA_SUB_APPROX_EN
// when the design is built with it.
module tb_aba_sub_pipe;

  localparam int W = 17;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_diff;
  logic         out_borrow;

  int checks = 0;
  int errors = 0;

  logic         s_acc, s_deq, s_vld, s_rdy, s_bor;
  logic [W-1:0] s_diff;

  always #5 clk = ~clk;

  aba_sub_pipe #(.WIDTH(W), .LCA_WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_diff   (out_diff),
    .out_borrow (out_borrow)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         borrow;
  } vec_t;

  vec_t vecs[$];

  // Reference result {borrow, diff}.
  function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb);
`ifdef ABA_SUB_APPROX_EN
    logic [W-4:0] t;
    t = {1'b0, ma[W-1:4]} + {1'b0, ~mb[W-1:4]} + {{(W-4){1'b0}}, ma[3]};
    return {~t[W-4], t[W-5:0], {4{ma[3]}}};
`else
    logic [W:0] t;
    t = {1'b0, ma} - {1'b0, mb};
    return t;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Drive at the falling edge, sample 1ns later; the handshake happens on the next rising edge.
  task automatic step(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input logic ordy);
    @(negedge clk);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    out_ready = ordy;
    #1;
    s_acc  = in_valid && in_ready;
    s_deq  = out_valid && out_ready;
    s_vld  = out_valid;
    s_rdy  = in_ready;
    s_diff = out_diff;
    s_bor  = out_borrow;
  endtask

  logic [W-1:0] pa [6];
  logic [W-1:0] pb [6];
  logic [W-1:0] va, vb;
  logic [W:0]   e;
  logic [W:0]   exp_q[$];
  int           idx, ridx, lat, last_c, acc_cnt, cyc, nv;
  bit           did_rst;

  initial begin
`ifdef ABA_SUB_APPROX_EN
    vecs.push_back('{17'h00018, 17'h00003, 17'h0001F, 1'b0});
    vecs.push_back('{17'h00010, 17'h00003, 17'h00000, 1'b0});
    vecs.push_back('{17'h00007, 17'h00020, 17'h1FFD0, 1'b1});
`else
    vecs.push_back('{17'h00010, 17'h00003, 17'h0000D, 1'b0});
    vecs.push_back('{17'h00000, 17'h00001, 17'h1FFFF, 1'b1});
    vecs.push_back('{17'h1ABCD, 17'h1ABCD, 17'h00000, 1'b0});
    vecs.push_back('{17'h1FFFF, 17'h00000, 17'h1FFFF, 1'b0});
    vecs.push_back('{17'h00000, 17'h1FFFF, 17'h00001, 1'b1});
    vecs.push_back('{17'h10000, 17'h00001, 17'h0FFFF, 1'b0});
    vecs.push_back('{17'h00005, 17'h00010, 17'h1FFF5, 1'b1});
    vecs.push_back('{17'h12345, 17'h01234, 17'h11111, 1'b0});
    vecs.push_back('{17'h0F0F0, 17'h10F0F, 17'h1E1E1, 1'b1});
`endif
    nv = vecs.size();

    pa = '{17'h00100, 17'h1FFFF, 17'h00007, 17'h0A5A5, 17'h12345, 17'h00000};
    pb = '{17'h00001, 17'h00001, 17'h00009, 17'h05A5A, 17'h12345, 17'h10000};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_diff", 32'(out_diff), 32'd0);
    chk("reset_out_borrow", 32'(out_borrow), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // Single items: latency and value
    for (int i = 0; i < nv; i++) begin
      step(1'b1, vecs[i].a, vecs[i].b, 1'b1);
      chk("single_accept", 32'(s_acc), 32'd1);
      lat = 0;
      for (int n = 1; n <= 8; n++) begin
        step(1'b0, '0, '0, 1'b1);
        if (s_vld) begin
          lat = n;
          break;
        end
      end
      chk("single_latency", 32'(lat), 32'd4);
      chk("single_diff", 32'(s_diff), 32'(vecs[i].diff));
      chk("single_borrow", 32'(s_bor), 32'(vecs[i].borrow));
    end

    // Back-to-back stream: one result per cycle, in order
    idx = 0; ridx = 0; last_c = -1;
    for (int c = 0; c < nv + 12 && ridx < nv; c++) begin
      va = '0; vb = '0;
      if (idx < nv) begin
        va = vecs[idx].a;
        vb = vecs[idx].b;
      end
      step(idx < nv, va, vb, 1'b1);
      if (s_deq) begin
        chk("stream_diff", 32'(s_diff), 32'(vecs[ridx].diff));
        chk("stream_borrow", 32'(s_bor), 32'(vecs[ridx].borrow));
        ridx++;
        if (ridx == nv) last_c = c;
      end
      if (s_acc) idx++;
    end
    chk("stream_count", 32'(ridx), 32'(nv));
    chk("stream_cycles", 32'(last_c), 32'(nv + 3));

    // Backpressure: 6 offered, only 4 fit while out_ready is low
    idx = 0; ridx = 0;
    for (int c = 0; c < 10; c++) begin
      va = '0; vb = '0;
      if (idx < 6) begin
        va = pa[idx];
        vb = pb[idx];
      end
      step(idx < 6, va, vb, 1'b0);
      if (s_acc) idx++;
    end
    e = model(pa[0], pb[0]);
    chk("bp_accepted", 32'(idx), 32'd4);
    chk("bp_in_ready", 32'(s_rdy), 32'd0);
    chk("bp_out_valid", 32'(s_vld), 32'd1);
    chk("bp_hold_diff", 32'(s_diff), 32'(e[W-1:0]));
    for (int c = 0; c < 3; c++) begin
      step(1'b1, pa[4], pb[4], 1'b0);
      chk("bp_frozen_acc", 32'(s_acc), 32'd0);
      chk("bp_frozen_diff", 32'(s_diff), 32'(e[W-1:0]));
      chk("bp_frozen_borrow", 32'(s_bor), 32'(e[W]));
    end
    for (int c = 0; c < 20 && ridx < 6; c++) begin
      va = '0; vb = '0;
      if (idx < 6) begin
        va = pa[idx];
        vb = pb[idx];
      end
      step(idx < 6, va, vb, 1'b1);
      if (s_deq) begin
        e = model(pa[ridx], pb[ridx]);
        chk("bp_drain_diff", 32'(s_diff), 32'(e[W-1:0]));
        chk("bp_drain_borrow", 32'(s_bor), 32'(e[W]));
        ridx++;
      end
      if (s_acc) idx++;
    end
    chk("bp_drain_count", 32'(ridx), 32'd6);
    chk("bp_total_accepted", 32'(idx), 32'd6);

    // Random handshakes with a reset in the middle
    acc_cnt = 0; cyc = 0; did_rst = 1'b0;
    while (acc_cnt < 10000 && cyc < 60000) begin
      if (!did_rst && acc_cnt == 5000) begin
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_reset_out_valid", 32'(out_valid), 32'd0);
        chk("mid_reset_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        did_rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
      end
      va = W'($urandom);
      vb = W'($urandom);
      step($urandom_range(0, 3) != 0, va, vb, $urandom_range(0, 3) != 0);
      if (s_deq) begin
        if (exp_q.size() == 0) begin
          chk("rnd_spurious_result", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rnd_diff", 32'(s_diff), 32'(e[W-1:0]));
          chk("rnd_borrow", 32'(s_bor), 32'(e[W]));
        end
      end
      if (s_acc) begin
        exp_q.push_back(model(va, vb));
        acc_cnt++;
      end
      cyc++;
    end
    chk("rnd_accepted", 32'(acc_cnt), 32'd10000);
    chk("rnd_reset_seen", 32'(did_rst), 32'd1);
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      step(1'b0, '0, '0, 1'b1);
      if (s_deq) begin
        e = exp_q.pop_front();
        chk("rnd_drain_diff", 32'(s_diff), 32'(e[W-1:0]));
        chk("rnd_drain_borrow", 32'(s_bor), 32'(e[W]));
      end
    end
    chk("rnd_queue_empty", 32'(exp_q.size()), 32'd0);
    step(1'b0, '0, '0, 1'b1);
    chk("rnd_idle_out_valid", 32'(s_vld), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aba_sub_pipe.md
ABA_SUB_PIPE -- requirements
Module: aba_sub_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 17, operand/result width; legal only as 4*NSEG+1.
REQ-002 SHALL have parameter LCA_WIDTH, default 4, segment width; only 4 is legal.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand pair a/b presented.
REQ-006 SHALL have port in_ready  output  1  block accepts the pair this cycle.
REQ-007 SHALL have port a  input  WIDTH  minuend.
REQ-008 SHALL have port b  input  WIDTH  subtrahend.
REQ-009 SHALL have port out_valid  output  1  out_diff/out_borrow hold a result.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-011 SHALL have port out_diff  output  WIDTH  a - b modulo 2^WIDTH.
REQ-012 SHALL have port out_borrow  output  1  1 when unsigned a < b, i.e. inverted final carry.

Function
REQ-013 SHALL compute a + ~b + 1: segment 0 (bits 3:0) carry-in is 1, each later segment takes the previous segment's carry-out, and the MSB is a full-adder bit.
REQ-014 SHALL use NSEG register stages: stage k resolves segment k, carries the partial sum, the next carry and the unresolved operand bits forward; the last stage also resolves the MSB.
REQ-015 SHALL advance all stages together on enable = !out_valid || out_ready; in_ready equals enable.
REQ-016 SHALL accept a pair on an edge where in_valid && in_ready; the result is on the outputs after edge t+NSEG-1 (4 cycles for WIDTH=17).
REQ-017 SHALL hold NSEG items in flight, keep order, and lose or duplicate nothing under any in_valid/out_ready pattern.
REQ-018 SHALL propagate bubbles: a stage loaded while its upstream valid is 0 becomes invalid.
REQ-019 SHALL keep out_diff/out_borrow stable while out_valid && !out_ready.
REQ-020 SHALL drop a result on an edge with out_valid && out_ready and load the next one on that same edge, so sustained throughput is one per cycle.
REQ-021 SHALL gate datapath registers with their valid flag to avoid toggling on bubbles; output data while out_valid=0 is don't-care.

Reset
REQ-022 SHALL clear all stage valid flags, out_valid, out_diff, out_borrow and internal carries to 0 immediately on rst_n low.
REQ-023 SHALL discard in-flight items on reset mid-operation; in_ready is 1 after release.

Configuration
REQ-024 SHALL, with ABA_SUB_APPROX_EN defined, not compute segment 0: out_diff[3:0] = {4{a[3]}} and carry into segment 1 = a[3].
REQ-025 SHALL, with ABA_SUB_APPROX_EN undefined, compute the exact difference; latency and handshake are identical in both builds.

Structure
REQ-026 SHALL place the NSEG derivation, the LCA_WIDTH constant and the stage-payload struct (valid, partial diff, carry, remaining a/~b bits) in shared package aba_pkg.
REQ-027 SHALL instantiate the existing 4-bit lookahead slice LCA4bit once per segment as its only sub-module; the MSB full-adder is inline.

Verification
REQ-028 Exact build, a=0x00010, b=0x00003, out_ready=1 -> out_diff=0x0000D, out_borrow=0, out_valid 4 cycles after accept.
REQ-029 Exact build, a=0x00000, b=0x00001 -> out_diff=0x1FFFF, out_borrow=1; a=b=0x1ABCD -> 0x00000, borrow=0.
REQ-030 ABA_SUB_APPROX_EN build, a=0x00018, b=0x00003 -> out_diff=0x0001F, borrow=0 (exact build gives 0x00015).
REQ-031 out_ready=0, 6 back-to-back pairs -> exactly 4 accepted, in_ready=0 after the 4th accept, outputs frozen; then out_ready=1 -> 4 results in order, then the remaining 2 are accepted.
REQ-032 Random in_valid/out_ready, 10k pairs -> scoreboard matches (a-b) mod 2^17 and borrow in order; reset asserted mid-stream -> out_valid=0 at once, no stale result after release.
